aref_scheduler: RTL



---
 rtl/aref_scheduler_if.sv | 25 ++
 rtl/aref_scheduler.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/aref_scheduler_if.sv
// rtl/aref_scheduler_if.sv - host-side and dispatcher-side instruction slots of the refresh scheduler
interface aref_scheduler_if;
    logic        host_en0;
    logic        host_en1;
    logic [31:0] host_instr0;
    logic [31:0] host_instr1;
    logic        host_ack0;
    logic        host_ack1;
    logic        en_in0;
    logic        en_in1;
    logic [31:0] instr_in0;
    logic [31:0] instr_in1;
    logic        en_ack0;
    logic        en_ack1;

    modport master (
        output host_en0, host_en1, host_instr0, host_instr1, en_ack0, en_ack1,
        input  host_ack0, host_ack1, en_in0, en_in1, instr_in0, instr_in1
    );

    modport slave (
        input  host_en0, host_en1, host_instr0, host_instr1, en_ack0, en_ack1,
        output host_ack0, host_ack1, en_in0, en_in1, instr_in0, instr_in1
    );
endinterface

// File: rtl/aref_scheduler.sv
// rtl/aref_scheduler.sv - auto-refresh scheduler; AREF_POSTPONE_EN enables postponing up to MAX_POSTPONE refreshes
module aref_scheduler #(
    parameter int unsigned TRP_CYCLES    = 4,
    parameter logic [31:0] PRE_ALL_INSTR = 32'h0,
    parameter logic [31:0] REF_INSTR     = 32'h0,
    parameter int unsigned MAX_POSTPONE  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               aref_set_interval_i,
    input  logic [27:0]        aref_interval_i,
    input  logic               aref_set_trfc_i,
    input  logic [27:0]        aref_trfc_i,
    aref_scheduler_if.slave    bus,
    output logic               aref_busy_o,
    output logic [3:0]         aref_pending_o,
    output logic               aref_missed_o
);

    if (TRP_CYCLES < 1 || MAX_POSTPONE < 1 || MAX_POSTPONE > 15) begin : g_bad_cfg
        $error("aref_scheduler: TRP_CYCLES must be >= 1 and MAX_POSTPONE in 1..15");
    end

`ifdef AREF_POSTPONE_EN
    localparam logic [3:0] LIMIT = 4'(MAX_POSTPONE);
`else
    localparam logic [3:0] LIMIT = 4'd1;
`endif

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_TRP, S_REF, S_TRFC} state_t;

    state_t      state_q, state_d;
    logic [27:0] interval_q, interval_d;
    logic [27:0] trfc_q, trfc_d;
    logic [27:0] tcnt_q, tcnt_d;
    logic [27:0] dcnt_q, dcnt_d;
    logic [3:0]  pending_q, pending_d;
    logic        missed_q, missed_d;
    logic        tick, ref_ack;
    logic        en0, en1, ack0, ack1;
    logic [31:0] instr0, instr1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            interval_q <= '0;
            trfc_q     <= '0;
            tcnt_q     <= '0;
            dcnt_q     <= '0;
            pending_q  <= '0;
            missed_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            interval_q <= interval_d;
            trfc_q     <= trfc_d;
            tcnt_q     <= tcnt_d;
            dcnt_q     <= dcnt_d;
            pending_q  <= pending_d;
            missed_q   <= missed_d;
        end
    end

    // Tick timer and owed-refresh bookkeeping
    always_comb begin
        tick       = (interval_q != '0) && (tcnt_q == interval_q - 28'd1) && !aref_set_interval_i;
        ref_ack    = (state_q == S_REF) && bus.en_ack0;
        interval_d = interval_q;
        trfc_d     = aref_set_trfc_i ? aref_trfc_i : trfc_q;
        pending_d  = pending_q;
        missed_d   = missed_q;
        if (aref_set_interval_i) begin
            interval_d = aref_interval_i;
            tcnt_d     = '0;
        end else if (interval_q == '0 || tick) begin
            tcnt_d     = '0;
        end else begin
            tcnt_d     = tcnt_q + 28'd1;
        end
        // A tick and a REF ack in the same cycle cancel out
        if (tick && !ref_ack) begin
            if (pending_q == LIMIT) missed_d = 1'b1;
            else                    pending_d = pending_q + 4'd1;
        end else if (ref_ack && !tick) begin
            pending_d = pending_q - 4'd1;
        end
        if (aref_set_interval_i) missed_d = 1'b0;
    end

    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        en0     = 1'b0;
        en1     = 1'b0;
        instr0  = '0;
        instr1  = '0;
        ack0    = 1'b0;
        ack1    = 1'b0;
        case (state_q)
            S_IDLE: begin
                en0    = bus.host_en0;
                en1    = bus.host_en1;
                instr0 = bus.host_instr0;
                instr1 = bus.host_instr1;
                ack0   = bus.en_ack0;
                ack1   = bus.en_ack1;
                if (pending_q != '0 && ((!bus.host_en0 && !bus.host_en1) || pending_q == LIMIT))
                    state_d = S_PRE;
            end
            S_PRE: begin
                en0    = 1'b1;
                instr0 = PRE_ALL_INSTR;
                if (bus.en_ack0) begin
                    dcnt_d  = 28'(TRP_CYCLES - 1);
                    state_d = S_TRP;
                end
            end
            S_TRP: begin
                if (dcnt_q == '0) state_d = S_REF;
                else              dcnt_d  = dcnt_q - 28'd1;
            end
            S_REF: begin
                en0    = 1'b1;
                instr0 = REF_INSTR;
                if (bus.en_ack0) begin
                    dcnt_d  = (trfc_q == '0) ? '0 : trfc_q - 28'd1;
                    state_d = S_TRFC;
                end
            end
            S_TRFC: begin
                if (dcnt_q == '0) state_d = S_IDLE;
                else              dcnt_d  = dcnt_q - 28'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are forced quiet while reset is held, even before the first edge
    assign bus.en_in0     = rst_n & en0;
    assign bus.en_in1     = rst_n & en1;
    assign bus.instr_in0  = rst_n ? instr0 : '0;
    assign bus.instr_in1  = rst_n ? instr1 : '0;
    assign bus.host_ack0  = rst_n & ack0;
    assign bus.host_ack1  = rst_n & ack1;
    assign aref_busy_o    = rst_n && (state_q != S_IDLE);
    assign aref_pending_o = rst_n ? pending_q : '0;
    assign aref_missed_o  = rst_n & missed_q;

endmodule
